timer_arbiter: RTL

TIMER_ARBITER -- requirements
Module: timer_arbiter

---
 rtl/timer_arbiter.sv | 103 ++++++++++
 1 files changed

// File: rtl/timer_arbiter.sv
// Round-robin arbiter granting one requester at a time a shared up-counter
// that runs from 0 to the requester's latched length, then pulses done.
module timer_arbiter #(
   parameter int unsigned NUM_REQ = 4,
   parameter int unsigned WIDTH   = 8
) (
   input  logic                     clk_i,
   input  logic                     rst_ni,
   input  logic [NUM_REQ-1:0]       req_i,
   input  logic [NUM_REQ*WIDTH-1:0] len_i,
   output logic [NUM_REQ-1:0]       gnt_o,
   output logic [NUM_REQ-1:0]       done_o,
   output logic                     busy_o,
   output logic [WIDTH-1:0]         count_o
);

   localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [IW-1:0]    idx_q, ptr_q, ptr_nxt;
   logic [WIDTH-1:0] len_q, cnt_q;
   logic             req_k;

   logic             win_vld;
   logic [IW-1:0]    win_idx, cand;
   logic [WIDTH-1:0] win_len;

   assign req_k   = req_i[idx_q];
   assign ptr_nxt = (idx_q == IW'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;

   // First requesting index scanning upward from ptr_q, wrapping mod NUM_REQ.
   always_comb begin
      win_vld = 1'b0;
      win_idx = '0;
      win_len = '0;
      cand    = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         cand = IW'((32'(ptr_q) + i) % NUM_REQ);
         if (!win_vld && req_i[cand]) begin
            win_vld = 1'b1;
            win_idx = cand;
            win_len = len_i[cand*WIDTH +: WIDTH];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         idx_q   <= '0;
         len_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            IDLE: begin
               if (win_vld) begin
                  idx_q <= win_idx;
                  len_q <= win_len;
                  cnt_q <= '0;
               end
            end
            RUN: begin
               if (req_k && (cnt_q != len_q)) cnt_q <= cnt_q + 1'b1;
            end
            default: ;
         endcase
         // Completion and abort share one exit path: advance pointer, clear counter.
         if ((state_q != IDLE) && (state_d == IDLE)) begin
            ptr_q <= ptr_nxt;
            cnt_q <= '0;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (win_vld) state_d = LOAD;
         LOAD:    state_d = req_k ? RUN : IDLE;
         RUN: begin
            if (!req_k)              state_d = IDLE;
            else if (cnt_q == len_q) state_d = DONE;
            else                     state_d = RUN;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      gnt_o   = '0;
      done_o  = '0;
      busy_o  = (state_q != IDLE);
      count_o = cnt_q;
      if (state_q != IDLE) gnt_o[idx_q]  = 1'b1;
      if (state_q == DONE) done_o[idx_q] = 1'b1;
   end

endmodule
